// File: rtl/inst_decode_unit_if.sv
// Decode-stage bus: fetch/writeback inputs and the registered ID/EX outputs.
// The master drives fetch, control and writeback; the slave (decode unit) drives id_*.
interface inst_decode_unit_if;
  logic [31:0] inst_code;
  logic [31:0] pc_in;
  logic        inst_valid;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  logic        id_alu_src_imm;
  logic        id_illegal;

  modport master (
    output inst_code, pc_in, inst_valid, stall, flush, wb_en, wb_rd, wb_data,
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7,
           id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_alu_src_imm, id_illegal
  );

  modport slave (
    input  inst_code, pc_in, inst_valid, stall, flush, wb_en, wb_rd, wb_data,
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7,
           id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_alu_src_imm, id_illegal
  );
endinterface

// File: rtl/inst_decode_unit.sv
// RV32I decode stage: field/immediate/control decode, 32x32 register file with
// write-through bypass, and the ID/EX stage register with stall and flush.
module inst_decode_unit (
  input  logic                 clk,
  input  logic                 reset,
  inst_decode_unit_if.slave    dec
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] regs [NREG];

  logic [XLEN-1:0] inst;
  logic [6:0]      opcode_c;
  logic [RW-1:0]   rs1_c, rs2_c, rd_c;
  logic [XLEN-1:0] rs1_data_c, rs2_data_c;
  logic [XLEN-1:0] imm_c;
  logic            reg_write_c, mem_read_c, mem_write_c, branch_c, jump_c;
  logic            alu_src_imm_c, illegal_c;
  logic            wb_fire_c;

  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [RW-1:0]   id_rs1_q, id_rs2_q, id_rd_q;
  logic [6:0]      id_opcode_q;
  logic [2:0]      id_funct3_q;
  logic [6:0]      id_funct7_q;
  logic [XLEN-1:0] id_rs1_data_q, id_rs2_data_q, id_imm_q;
  logic            id_reg_write_q, id_mem_read_q, id_mem_write_q;
  logic            id_branch_q, id_jump_q, id_alu_src_imm_q, id_illegal_q;

  assign inst      = dec.inst_code;
  assign opcode_c  = inst[6:0];
  assign rs1_c     = inst[19:15];
  assign rs2_c     = inst[24:20];
  assign rd_c      = inst[11:7];
  assign wb_fire_c = dec.wb_en && (dec.wb_rd != '0);

  // Operand read: x0 is hard-wired, a same-cycle writeback bypasses the array
  always_comb begin
    rs1_data_c = regs[rs1_c];
    rs2_data_c = regs[rs2_c];
    if (wb_fire_c && (dec.wb_rd == rs1_c)) rs1_data_c = dec.wb_data;
    if (wb_fire_c && (dec.wb_rd == rs2_c)) rs2_data_c = dec.wb_data;
    if (rs1_c == '0) rs1_data_c = '0;
    if (rs2_c == '0) rs2_data_c = '0;
  end

  // Control flags and immediate selection by opcode class
  always_comb begin
    reg_write_c   = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    branch_c      = 1'b0;
    jump_c        = 1'b0;
    alu_src_imm_c = 1'b0;
    illegal_c     = 1'b0;
    imm_c         = '0;
    case (opcode_c)
      OPC_LUI, OPC_AUIPC: begin
        reg_write_c   = 1'b1;
        alu_src_imm_c = 1'b1;
        imm_c         = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        reg_write_c = 1'b1;
        jump_c      = 1'b1;
        imm_c       = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        reg_write_c   = 1'b1;
        jump_c        = 1'b1;
        alu_src_imm_c = 1'b1;
        imm_c         = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        branch_c = 1'b1;
        imm_c    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LOAD: begin
        reg_write_c   = 1'b1;
        mem_read_c    = 1'b1;
        alu_src_imm_c = 1'b1;
        imm_c         = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        mem_write_c   = 1'b1;
        alu_src_imm_c = 1'b1;
        imm_c         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OPIMM: begin
        reg_write_c   = 1'b1;
        alu_src_imm_c = 1'b1;
        imm_c         = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP: begin
        reg_write_c = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

  // Register file write port; independent of stall and flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wb_fire_c) begin
      regs[dec.wb_rd] <= dec.wb_data;
    end
  end

  // ID/EX stage register: flush > stall > bubble > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset || dec.flush) begin
      id_valid_q       <= 1'b0;
      id_pc_q          <= '0;
      id_rs1_q         <= '0;
      id_rs2_q         <= '0;
      id_rd_q          <= '0;
      id_opcode_q      <= '0;
      id_funct3_q      <= '0;
      id_funct7_q      <= '0;
      id_rs1_data_q    <= '0;
      id_rs2_data_q    <= '0;
      id_imm_q         <= '0;
      id_reg_write_q   <= 1'b0;
      id_mem_read_q    <= 1'b0;
      id_mem_write_q   <= 1'b0;
      id_branch_q      <= 1'b0;
      id_jump_q        <= 1'b0;
      id_alu_src_imm_q <= 1'b0;
      id_illegal_q     <= 1'b0;
    end else if (dec.stall) begin
      // Held operands track writeback so they never go stale
      if (wb_fire_c && (dec.wb_rd == id_rs1_q)) id_rs1_data_q <= dec.wb_data;
      if (wb_fire_c && (dec.wb_rd == id_rs2_q)) id_rs2_data_q <= dec.wb_data;
    end else begin
      id_valid_q       <= dec.inst_valid;
      id_pc_q          <= dec.pc_in;
      id_rs1_q         <= rs1_c;
      id_rs2_q         <= rs2_c;
      id_rd_q          <= rd_c;
      id_opcode_q      <= opcode_c;
      id_funct3_q      <= inst[14:12];
      id_funct7_q      <= inst[31:25];
      id_rs1_data_q    <= rs1_data_c;
      id_rs2_data_q    <= rs2_data_c;
      id_imm_q         <= imm_c;
      id_reg_write_q   <= dec.inst_valid && reg_write_c;
      id_mem_read_q    <= dec.inst_valid && mem_read_c;
      id_mem_write_q   <= dec.inst_valid && mem_write_c;
      id_branch_q      <= dec.inst_valid && branch_c;
      id_jump_q        <= dec.inst_valid && jump_c;
      id_alu_src_imm_q <= dec.inst_valid && alu_src_imm_c;
      id_illegal_q     <= dec.inst_valid && illegal_c;
    end
  end

  assign dec.id_valid       = id_valid_q;
  assign dec.id_pc          = id_pc_q;
  assign dec.id_rs1         = id_rs1_q;
  assign dec.id_rs2         = id_rs2_q;
  assign dec.id_rd          = id_rd_q;
  assign dec.id_opcode      = id_opcode_q;
  assign dec.id_funct3      = id_funct3_q;
  assign dec.id_funct7      = id_funct7_q;
  assign dec.id_rs1_data    = id_rs1_data_q;
  assign dec.id_rs2_data    = id_rs2_data_q;
  assign dec.id_imm         = id_imm_q;
  assign dec.id_reg_write   = id_reg_write_q;
  assign dec.id_mem_read    = id_mem_read_q;
  assign dec.id_mem_write   = id_mem_write_q;
  assign dec.id_branch      = id_branch_q;
  assign dec.id_jump        = id_jump_q;
  assign dec.id_alu_src_imm = id_alu_src_imm_q;
  assign dec.id_illegal     = id_illegal_q;
endmodule

// File: tb/tb_inst_decode_unit.sv
// Directed bench for inst_decode_unit: hand-computed decode, bypass, stall,
// flush, bubble and asynchronous reset expectations.
module tb_inst_decode_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  inst_decode_unit_if u_if ();

  inst_decode_unit dut (
    .clk   (clk),
    .reset (reset),
    .dec   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] code, input logic [31:0] pc, input logic vld);
    u_if.inst_code  = code;
    u_if.pc_in      = pc;
    u_if.inst_valid = vld;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    u_if.wb_en   = en;
    u_if.wb_rd   = rd;
    u_if.wb_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    u_if.stall = 1'b0;
    u_if.flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    check("rst_valid", 32'(u_if.id_valid), 32'h0);
    check("rst_pc", u_if.id_pc, 32'h0);
    check("rst_imm", u_if.id_imm, 32'h0);
    reset = 1'b0;

    // Write x5, then decode addi x6,x5,-1
    wb(1'b1, 5'd5, 32'h12345678);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(32'hFFF28313, 32'h0000_0100, 1'b1);
    tick();
    check("addi_valid", 32'(u_if.id_valid), 32'h1);
    check("addi_rs1_data", u_if.id_rs1_data, 32'h12345678);
    check("addi_imm", u_if.id_imm, 32'hFFFFFFFF);
    check("addi_reg_write", 32'(u_if.id_reg_write), 32'h1);
    check("addi_alu_imm", 32'(u_if.id_alu_src_imm), 32'h1);
    check("addi_rd", 32'(u_if.id_rd), 32'd6);
    check("addi_rs1", 32'(u_if.id_rs1), 32'd5);
    check("addi_opcode", 32'(u_if.id_opcode), 32'h13);
    check("addi_pc", u_if.id_pc, 32'h100);

    // sw x2,-4(x1) with x1=0x100, x2=0xAB
    drive(32'h0, 32'h0, 1'b0);
    wb(1'b1, 5'd1, 32'h100);
    tick();
    wb(1'b1, 5'd2, 32'hAB);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(32'hFE20AE23, 32'h104, 1'b1);
    tick();
    check("sw_mem_write", 32'(u_if.id_mem_write), 32'h1);
    check("sw_reg_write", 32'(u_if.id_reg_write), 32'h0);
    check("sw_imm", u_if.id_imm, 32'hFFFFFFFC);
    check("sw_rs1_data", u_if.id_rs1_data, 32'h100);
    check("sw_rs2_data", u_if.id_rs2_data, 32'hAB);
    check("sw_funct3", 32'(u_if.id_funct3), 32'h2);

    // beq with all-ones offset bits: imm -4
    drive(32'hFE000EE3, 32'h108, 1'b1);
    tick();
    check("beq_imm", u_if.id_imm, 32'hFFFFFFFC);
    check("beq_branch", 32'(u_if.id_branch), 32'h1);
    check("beq_reg_write", 32'(u_if.id_reg_write), 32'h0);
    // beq with imm[10:5]=0: 0xFFFFF81C
    drive(32'h80000EE3, 32'h10C, 1'b1);
    tick();
    check("beq2_imm", u_if.id_imm, 32'hFFFFF81C);
    drive(32'h0000006F, 32'h110, 1'b1);
    tick();
    check("jal_imm", u_if.id_imm, 32'h0);
    check("jal_jump", 32'(u_if.id_jump), 32'h1);
    check("jal_reg_write", 32'(u_if.id_reg_write), 32'h1);
    check("jal_branch", 32'(u_if.id_branch), 32'h0);
    // lui x7,0x12345
    drive(32'h123453B7, 32'h114, 1'b1);
    tick();
    check("lui_imm", u_if.id_imm, 32'h12345000);
    check("lui_rd", 32'(u_if.id_rd), 32'd7);

    // Same-cycle bypass on add x4,x3,x3
    wb(1'b1, 5'd3, 32'hDEAD);
    drive(32'h00318233, 32'h118, 1'b1);
    tick();
    check("byp_rs1_data", u_if.id_rs1_data, 32'hDEAD);
    check("byp_rs2_data", u_if.id_rs2_data, 32'hDEAD);
    check("add_imm", u_if.id_imm, 32'h0);
    check("add_alu_imm", 32'(u_if.id_alu_src_imm), 32'h0);
    // x0 writes are dropped and never bypassed
    wb(1'b1, 5'd0, 32'hFFFF);
    drive(32'h00000233, 32'h11C, 1'b1);
    tick();
    check("x0_byp_rs1", u_if.id_rs1_data, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("x0_rs2", u_if.id_rs2_data, 32'h0);

    // Stall 3 cycles with writeback to held rs1 in cycle 2
    drive(32'hFFF28313, 32'h200, 1'b1);
    tick();
    u_if.stall = 1'b1;
    drive(32'hFE20AE23, 32'h300, 1'b1);
    tick();
    check("stall1_pc", u_if.id_pc, 32'h200);
    check("stall1_rs1_data", u_if.id_rs1_data, 32'h12345678);
    wb(1'b1, 5'd5, 32'hCAFEF00D);
    tick();
    check("stall2_rs1_data", u_if.id_rs1_data, 32'hCAFEF00D);
    check("stall2_rd", 32'(u_if.id_rd), 32'd6);
    check("stall2_imm", u_if.id_imm, 32'hFFFFFFFF);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("stall3_rs1_data", u_if.id_rs1_data, 32'hCAFEF00D);
    check("stall3_pc", u_if.id_pc, 32'h200);
    check("stall3_valid", 32'(u_if.id_valid), 32'h1);
    u_if.flush = 1'b1;
    tick();
    check("flush_valid", 32'(u_if.id_valid), 32'h0);
    check("flush_reg_write", 32'(u_if.id_reg_write), 32'h0);
    check("flush_alu_imm", 32'(u_if.id_alu_src_imm), 32'h0);
    u_if.stall = 1'b0;
    u_if.flush = 1'b0;

    // Illegal opcode, FENCE, bubble
    drive(32'h0000007F, 32'h400, 1'b1);
    tick();
    check("ill_illegal", 32'(u_if.id_illegal), 32'h1);
    check("ill_valid", 32'(u_if.id_valid), 32'h1);
    check("ill_reg_write", 32'(u_if.id_reg_write), 32'h0);
    drive(32'h0000000F, 32'h404, 1'b1);
    tick();
    check("fence_illegal", 32'(u_if.id_illegal), 32'h0);
    check("fence_valid", 32'(u_if.id_valid), 32'h1);
    drive(32'hFFF28313, 32'h408, 1'b0);
    tick();
    check("bubble_valid", 32'(u_if.id_valid), 32'h0);
    check("bubble_reg_write", 32'(u_if.id_reg_write), 32'h0);
    check("bubble_pc", u_if.id_pc, 32'h408);
    check("bubble_rd", 32'(u_if.id_rd), 32'd6);

    // Asynchronous reset mid-stall, then x5 reads 0
    drive(32'hFFF28313, 32'h500, 1'b1);
    tick();
    u_if.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(u_if.id_valid), 32'h0);
    check("async_rst_pc", u_if.id_pc, 32'h0);
    check("async_rst_rs1_data", u_if.id_rs1_data, 32'h0);
    tick();
    reset = 1'b0;
    u_if.stall = 1'b0;
    tick();
    check("post_rst_x5", u_if.id_rs1_data, 32'h0);
    check("post_rst_valid", 32'(u_if.id_valid), 32'h1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
